best_reporter: RTL
==================

BEST_REPORTER -- requirements
Module: best_reporter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk_i cycles per UART bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter REPORT_PERIOD, default 100000000, giving idle clk_i cycles between report attempts.
REQ-003 clk_i  input  1  the single clock; all state on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 best_nonce_i  input  256  current best nonce from the best-hash tracker.
REQ-006 best_bits_off_i  input  10  current best bits-off value; 10'h3FF means "no result yet".
REQ-007 clear_best_o  output  1  one-cycle pulse that resets the best-hash tracker.
REQ-008 tx_o  output  1  UART 8N1 serial line, idle high.
REQ-009 busy_o  output  1  high from snapshot until the last stop bit of a report completes.

Function
REQ-010 An idle timer SHALL count clk_i cycles only while in IDLE, and SHALL expire when it reaches REPORT_PERIOD-1.
REQ-011 On expiry with best_bits_off_i == 10'h3FF, the block SHALL stay in IDLE, clear the timer, and neither transmit nor pulse clear_best_o.
REQ-012 On expiry with best_bits_off_i != 10'h3FF, the block SHALL enter LOAD and register both inputs into a snapshot.
REQ-013 clear_best_o SHALL be high for exactly the LOAD cycle, so results found during transmission accumulate for the next report.
REQ-014 Each frame SHALL be 70 bytes: 3 uppercase hex digits of {2'b00, bits_off}, then ':' (0x3A), then 64 uppercase hex digits of the nonce MSB nibble first, then CR (0x0D) and LF (0x0A).
REQ-015 Frame bytes SHALL come only from the snapshot; input changes after LOAD SHALL NOT affect the frame in progress.
REQ-016 The FSM states SHALL be IDLE, LOAD, START, DATA, STOP and NEXT.
REQ-017 Transitions: IDLE->LOAD on qualified expiry; LOAD->START; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits, LSB first, CLKS_PER_BIT cycles each; STOP->NEXT after CLKS_PER_BIT cycles.
REQ-018 NEXT SHALL last one cycle with tx_o high, then go to START if byte index < 69, else to IDLE with a cleared timer and an index of 0.
REQ-019 tx_o levels: 0 in START, the data bit in DATA, 1 in all other states.
REQ-020 One frame SHALL last exactly 70*(10*CLKS_PER_BIT+1) cycles from the first START cycle to the return to IDLE.
REQ-021 The nibble-to-ASCII mapping SHALL give 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46.
REQ-022 The byte index (7 bits), bit index (3 bits) and baud counter SHALL each wrap to 0 on use; none SHALL overflow.

Reset
REQ-023 While rst_ni is low, outputs SHALL immediately be tx_o=1, clear_best_o=0, busy_o=0.
REQ-024 While rst_ni is low, the state SHALL be IDLE and all counters and the snapshot SHALL be 0.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no partial resume, and the timer SHALL restart from 0 after release.

Structure
REQ-026 A shared package SHALL hold the state enum, FRAME_LEN=70, ASCII_COLON, ASCII_CR and ASCII_LF.
REQ-027 The byte serializer (START/DATA/STOP timing) SHALL be a sub-module uart_tx, with a byte+valid input and a done pulse output.
REQ-028 Frame sequencing, the timer and hex encoding SHALL stay in best_reporter.

Verification (CLKS_PER_BIT=4, REPORT_PERIOD=16)
REQ-029 Reset: rst_ni low mid-run -> tx_o=1, busy_o=0 and clear_best_o=0 in the same cycle, with no glitch after release.
REQ-030 No result: best_bits_off_i=10'h3FF for 100 cycles -> tx_o constant 1 and no clear_best_o pulse.
REQ-031 Nominal: bits_off=10'h02A, nonce=256'h0123...CDEF repeated -> decoded bytes "02A:0123...CDEF\r\n", 70 bytes, clear_best_o high once, on the cycle 16 after the timer starts.
REQ-032 Input change: best_nonce_i changed to all-ones at byte 10 -> the frame still matches the snapshot.
REQ-033 Timing: frame length is exactly 70*41=2870 cycles, then the next report follows after a further 16 idle cycles.
REQ-034 Mid-frame abort: rst_ni pulsed during a DATA bit of byte 5 -> tx_o high at once, and a full new frame follows the next expiry.

Source files
------------

// File: rtl/best_reporter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : best_reporter_pkg
// Description : Shared types and constants for the best-result UART reporter:
//               the FSM state encoding, frame length and the fixed ASCII
//               delimiters used in every report frame.
// Revision    : 1.0 - initial release
// ============================================================================
package best_reporter_pkg;

  // Full reporter state set. The top sequencer owns IDLE/LOAD/START/NEXT,
  // the serializer refines a launched byte into START/DATA/STOP.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_NEXT  = 3'd5
  } state_e;

  typedef logic [255:0] nonce_t;
  typedef logic [9:0]   bits_off_t;

  // Bytes per report: 3 hex + ':' + 64 hex + CR + LF
  localparam int unsigned FRAME_LEN     = 70;
  localparam logic [7:0]  ASCII_COLON   = 8'h3A;
  localparam logic [7:0]  ASCII_CR      = 8'h0D;
  localparam logic [7:0]  ASCII_LF      = 8'h0A;

  // Tracker value meaning "nothing found yet"
  localparam bits_off_t   BITS_OFF_NONE = 10'h3FF;

endpackage
`default_nettype wire

// File: rtl/best_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : best_reporter_if
// Description : Link between the best-hash tracker and the reporter.
//               Signal names are from the reporter's point of view.
//   best_nonce_i    : current best nonce (tracker -> reporter)
//   best_bits_off_i : current best bits-off, 10'h3FF = no result
//   clear_best_o    : one-cycle clear pulse (reporter -> tracker)
//   modport master  : tracker side
//   modport slave   : reporter side
// Revision    : 1.0 - initial release
// ============================================================================
interface best_reporter_if;
  import best_reporter_pkg::*;

  nonce_t    best_nonce_i;
  bits_off_t best_bits_off_i;
  logic      clear_best_o;

  modport master (
    output best_nonce_i,
    output best_bits_off_i,
    input  clear_best_o
  );

  modport slave (
    input  best_nonce_i,
    input  best_bits_off_i,
    output clear_best_o
  );

endinterface
`default_nettype wire

// File: rtl/best_reporter_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 byte serializer. A byte presented with valid_i while
//               idle is sent as START, 8 data bits LSB first, STOP, each
//               CLKS_PER_BIT cycles long. done_o pulses on the final cycle
//               of the stop bit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   data_i        : byte to send
//   valid_i       : launch request, honoured only while idle
//   tx_o          : serial line, idle high
//   done_o        : one-cycle pulse, last stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import best_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_STOP  = ST_STOP;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          w_baud_end;

  assign w_baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          shift_d = data_i;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;   // wraps back to 0 after bit 7
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          baud_d  = '0;
          done_o  = 1'b1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level decoded from state so reset forces the line high immediately
  always_comb begin
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[bit_q];
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/best_reporter.sv
`default_nettype none
// ============================================================================
// Module      : best_reporter
// Description : Periodically snapshots the best-hash tracker and sends the
//               result as an ASCII line "BBB:NNNN...NNNN\r\n" over UART 8N1.
//               An idle timer triggers each report attempt; attempts with no
//               result are skipped silently. The tracker is cleared in the
//               snapshot cycle so new results accumulate during transmission.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tracker       : best nonce / bits-off in, clear pulse out
//   tx_o          : UART serial line, idle high
//   busy_o        : high from snapshot until the frame is finished
// Revision    : 1.0 - initial release
// ============================================================================
module best_reporter
  import best_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int REPORT_PERIOD = 100000000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  best_reporter_if.slave tracker,
  output logic           tx_o,
  output logic           busy_o
);

  localparam int unsigned   TW         = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_PERIOD - 1);
  localparam logic [6:0]    LAST_IDX   = 7'(FRAME_LEN - 1);

  // Sequencer states. While in START the serializer owns the byte and steps
  // through its own START/DATA/STOP phases; done brings us to NEXT.
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_NEXT  = ST_NEXT;

  logic [2:0]    ctl_q,   ctl_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    idx_q,   idx_d;
  nonce_t        nonce_q, nonce_d;
  bits_off_t     bits_q,  bits_d;

  logic          w_launch;
  logic          w_done;
  logic [6:0]    w_launch_idx;
  logic [5:0]    w_nib_sel;
  logic [11:0]   w_hdr;
  logic [7:0]    w_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};   // 0xA -> 0x41 'A'
  endfunction

  // --------------------------------------------------------------------------
  // Sequencer, idle timer and snapshot
  // --------------------------------------------------------------------------
  always_comb begin
    ctl_d    = ctl_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    nonce_d  = nonce_q;
    bits_d   = bits_q;
    w_launch = 1'b0;
    case (ctl_q)
      S_IDLE: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (tracker.best_bits_off_i != BITS_OFF_NONE) begin
            nonce_d = tracker.best_nonce_i;
            bits_d  = tracker.best_bits_off_i;
            ctl_d   = S_LOAD;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LOAD: begin
        w_launch = 1'b1;
        idx_d    = '0;
        ctl_d    = S_START;
      end
      S_START: begin
        if (w_done) begin
          ctl_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q < LAST_IDX) begin
          w_launch = 1'b1;
          idx_d    = idx_q + 1'b1;
          ctl_d    = S_START;
        end else begin
          idx_d   = '0;
          timer_d = '0;
          ctl_d   = S_IDLE;
        end
      end
      default: begin
        ctl_d   = S_IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame byte generation from the snapshot only
  // --------------------------------------------------------------------------
  assign w_launch_idx = (ctl_q == S_LOAD) ? 7'd0 : (idx_q + 7'd1);
  assign w_hdr        = {2'b00, bits_q};
  // Nonce nibble for bytes 4..67, MSB nibble first: nibble 67-idx, taken mod 64
  assign w_nib_sel    = 6'd3 - w_launch_idx[5:0];

  always_comb begin
    w_byte = 8'h00;
    if (w_launch_idx == 7'd0) begin
      w_byte = hex_ascii(w_hdr[11:8]);
    end else if (w_launch_idx == 7'd1) begin
      w_byte = hex_ascii(w_hdr[7:4]);
    end else if (w_launch_idx == 7'd2) begin
      w_byte = hex_ascii(w_hdr[3:0]);
    end else if (w_launch_idx == 7'd3) begin
      w_byte = ASCII_COLON;
    end else if (w_launch_idx == LAST_IDX - 7'd1) begin
      w_byte = ASCII_CR;
    end else if (w_launch_idx == LAST_IDX) begin
      w_byte = ASCII_LF;
    end else begin
      w_byte = hex_ascii(nonce_q[{w_nib_sel, 2'b00} +: 4]);
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (w_byte),
    .valid_i (w_launch),
    .tx_o    (tx_o),
    .done_o  (w_done)
  );

  // Outputs decode registered state: reset forces them inactive at once
  assign tracker.clear_best_o = (ctl_q == S_LOAD);
  assign busy_o               = (ctl_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctl_q   <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      nonce_q <= '0;
      bits_q  <= '0;
    end else begin
      ctl_q   <= ctl_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      nonce_q <= nonce_d;
      bits_q  <= bits_d;
    end
  end

endmodule
`default_nettype wire
